// File: rtl/node_indexer.sv
// node_indexer: assigns a dense index to each distinct 3-letter node name.
// Each source and destination name is looked up in a name table that is
// addressed directly by the packed name. A name not seen before gets the next
// free index. Every edge event is reported as an indexed (src, dst) pair.
module node_indexer #(
  parameter int INDEX_WIDTH = 10,
  parameter int NODE_WIDTH  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   src_node_valid,
  input  logic [NODE_WIDTH-1:0]  src_node,
  input  logic                   edge_valid,
  input  logic [NODE_WIDTH-1:0]  dst_node,
  input  logic                   decoding_done,
  output logic                   init_done,
  output logic                   idx_edge_valid,
  output logic [INDEX_WIDTH-1:0] src_idx,
  output logic [INDEX_WIDTH-1:0] dst_idx,
  output logic [INDEX_WIDTH:0]   node_count,
  output logic [15:0]            edge_count,
  output logic                   indexing_done,
  output logic                   error
);

  localparam int DEPTH = 1 << NODE_WIDTH;

  typedef enum logic [2:0] {INIT, IDLE, READ, RESOLVE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [NODE_WIDTH-1:0]  init_addr_reg;
  logic [NODE_WIDTH-1:0]  name_reg;
  logic                   is_edge_reg;
  logic                   done_latch_reg;
  logic                   init_done_reg;
  logic                   idx_edge_valid_reg;
  logic [INDEX_WIDTH-1:0] src_idx_reg;
  logic [INDEX_WIDTH-1:0] dst_idx_reg;
  logic [INDEX_WIDTH:0]   node_count_reg;
  logic [15:0]            edge_count_reg;
  logic                   indexing_done_reg;
  logic                   error_reg;

  // Name table: each entry is {valid, index}, read one cycle after the address.
  logic [INDEX_WIDTH:0]   table_mem [DEPTH];
  logic [INDEX_WIDTH:0]   rd_data_reg;

  logic                   any_event;
  logic                   hit;
  logic                   full;
  logic                   alloc;
  logic                   start_event;
  logic                   err_set;
  logic [INDEX_WIDTH-1:0] resolved_idx;
  logic                   ram_we;
  logic [NODE_WIDTH-1:0]  ram_waddr;
  logic [INDEX_WIDTH:0]   ram_wdata;

  assign any_event = src_node_valid | edge_valid;
  assign hit       = rd_data_reg[INDEX_WIDTH];
  // node_count saturates at 2^INDEX_WIDTH, so its top bit means "table full".
  assign full      = node_count_reg[INDEX_WIDTH];
  assign alloc     = (state_reg == RESOLVE) && !hit && !full;

  // Hit uses the stored index; a miss takes the next free index, or the last
  // index once the index space is exhausted.
  assign resolved_idx = hit  ? rd_data_reg[INDEX_WIDTH-1:0] :
                        full ? {INDEX_WIDTH{1'b1}} : node_count_reg[INDEX_WIDTH-1:0];

  // The INIT sweep and allocations never occur in the same cycle.
  assign ram_we    = (state_reg == INIT) || alloc;
  assign ram_waddr = (state_reg == INIT) ? init_addr_reg : name_reg;
  assign ram_wdata = (state_reg == INIT) ? '0 : {1'b1, node_count_reg[INDEX_WIDTH-1:0]};

  // Name table write port and registered read of the captured name.
  always_ff @(posedge clk) begin
    if (ram_we) table_mem[ram_waddr] <= ram_wdata;
    rd_data_reg <= table_mem[name_reg];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= INIT;
    else        state_reg <= state_next;
  end

  // Next state, event acceptance and error detection.
  always_comb begin
    state_next  = state_reg;
    start_event = 1'b0;
    err_set     = 1'b0;
    case (state_reg)
      INIT: begin
        if (any_event || decoding_done) err_set = 1'b1;
        if (&init_addr_reg) state_next = IDLE;
      end
      IDLE: begin
        if (done_latch_reg) begin
          state_next = DONE;
        end else if (any_event) begin
          start_event = 1'b1;
          state_next  = READ;
          // Both pulses together: the edge wins, the src event is lost.
          if (src_node_valid && edge_valid) err_set = 1'b1;
        end
      end
      READ: begin
        state_next = RESOLVE;
        if (any_event) err_set = 1'b1;
      end
      RESOLVE: begin
        state_next = IDLE;
        if (any_event || (!hit && full)) err_set = 1'b1;
      end
      DONE: state_next = DONE;
      default: state_next = INIT;
    endcase
  end

  // Datapath registers: INIT sweep, event capture, resolution and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr_reg      <= '0;
      init_done_reg      <= 1'b0;
      name_reg           <= '0;
      is_edge_reg        <= 1'b0;
      done_latch_reg     <= 1'b0;
      idx_edge_valid_reg <= 1'b0;
      src_idx_reg        <= '0;
      dst_idx_reg        <= '0;
      node_count_reg     <= '0;
      edge_count_reg     <= '0;
      indexing_done_reg  <= 1'b0;
      error_reg          <= 1'b0;
    end else begin
      idx_edge_valid_reg <= 1'b0;
      indexing_done_reg  <= 1'b0;
      if (state_reg == INIT) begin
        init_addr_reg <= init_addr_reg + NODE_WIDTH'(1);
        if (&init_addr_reg) init_done_reg <= 1'b1;
      end
      if (decoding_done && state_reg != INIT && state_reg != DONE)
        done_latch_reg <= 1'b1;
      if (start_event) begin
        name_reg    <= edge_valid ? dst_node : src_node;
        is_edge_reg <= edge_valid;
      end
      if (state_reg == RESOLVE) begin
        if (is_edge_reg) begin
          dst_idx_reg        <= resolved_idx;
          idx_edge_valid_reg <= 1'b1;
          edge_count_reg     <= edge_count_reg + 16'd1;
        end else begin
          src_idx_reg <= resolved_idx;
        end
      end
      if (alloc) node_count_reg <= node_count_reg + (INDEX_WIDTH+1)'(1);
      if (state_reg == IDLE && done_latch_reg) indexing_done_reg <= 1'b1;
      if (err_set) error_reg <= 1'b1;
    end
  end

  assign init_done      = init_done_reg;
  assign idx_edge_valid = idx_edge_valid_reg;
  assign src_idx        = src_idx_reg;
  assign dst_idx        = dst_idx_reg;
  assign node_count     = node_count_reg;
  assign edge_count     = edge_count_reg;
  assign indexing_done  = indexing_done_reg;
  assign error          = error_reg;

endmodule

// File: tb/tb_node_indexer.sv
// Testbench for node_indexer: two instances (default width and a 2-bit index),
// a name->index model, and a per-cycle compare of the indexed edge stream.
module tb_node_indexer;

  localparam int SRC = 0, EDG = 1, DON = 2;
  localparam int NAAA = 0,    NBBB = 1057, NCCC = 2114, NDDD = 3171, NEEE = 4228;
  localparam int NFFF = 5285, NGGG = 6342, NHHH = 7399, NYOU = 20952, NOUT = 20110;
  localparam int INIT_CYCLES = 32768;

  logic clk;
  logic [1:0] rstn, snv, env, ddv;
  logic [1:0][14:0] sn, dn;

  logic iev_a, initd_a, idone_a, err_a;
  logic iev_b, initd_b, idone_b, err_b;
  logic [9:0] sidx_a, didx_a;
  logic [10:0] ncnt_a;
  logic [1:0] sidx_b, didx_b;
  logic [2:0] ncnt_b;
  logic [15:0] ecnt_a, ecnt_b;

  logic [1:0] iev, initd, idone, errs;
  logic [1:0][9:0] sidx, didx;
  logic [1:0][10:0] ncnt;
  logic [1:0][15:0] ecnt;

  assign iev   = {iev_b, iev_a};
  assign initd = {initd_b, initd_a};
  assign idone = {idone_b, idone_a};
  assign errs  = {err_b, err_a};
  assign sidx  = {10'(sidx_b), sidx_a};
  assign didx  = {10'(didx_b), didx_a};
  assign ncnt  = {11'(ncnt_b), ncnt_a};
  assign ecnt  = {ecnt_b, ecnt_a};

  node_indexer dut_a (
    .clk(clk), .rst_n(rstn[0]),
    .src_node_valid(snv[0]), .src_node(sn[0]),
    .edge_valid(env[0]), .dst_node(dn[0]), .decoding_done(ddv[0]),
    .init_done(initd_a), .idx_edge_valid(iev_a),
    .src_idx(sidx_a), .dst_idx(didx_a),
    .node_count(ncnt_a), .edge_count(ecnt_a),
    .indexing_done(idone_a), .error(err_a)
  );

  node_indexer #(.INDEX_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rstn[1]),
    .src_node_valid(snv[1]), .src_node(sn[1]),
    .edge_valid(env[1]), .dst_node(dn[1]), .decoding_done(ddv[1]),
    .init_done(initd_b), .idx_edge_valid(iev_b),
    .src_idx(sidx_b), .dst_idx(didx_b),
    .node_count(ncnt_b), .edge_count(ecnt_b),
    .indexing_done(idone_b), .error(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int dut; int cyc; int src; int dst; int ec;} exp_t;
  typedef struct {int cyc; int src; int dst;} obs_t;
  exp_t expq[$];
  obs_t obs_a[$], obs_b[$];

  int mtab[int];            // key = dut*65536 + name
  int mcount[2], medges[2], msrc[2], mlast[2], mrel[2];
  bit merr[2], mdone[2];

  function automatic bit mready(input int d);
    return (rstn[d] == 1'b1) && (cyc >= mrel[d] + INIT_CYCLES);
  endfunction

  function automatic int mlookup(input int d, input int name);
    int key, cap, idx;
    key = d * 65536 + name;
    cap = (d == 0) ? 1024 : 4;
    if (mtab.exists(key)) return mtab[key];
    if (mcount[d] < cap) begin
      idx = mcount[d];
      mtab[key] = idx;
      mcount[d]++;
    end else begin
      idx = cap - 1;
      merr[d] = 1'b1;
    end
    return idx;
  endfunction

  function automatic void model_event(input int d, input int kind, input int name);
    exp_t e;
    int idx;
    if (!mready(d)) begin merr[d] = 1'b1; return; end
    if (mdone[d]) return;
    if (kind == DON) begin mdone[d] = 1'b1; return; end
    if (cyc - mlast[d] < 3) begin merr[d] = 1'b1; return; end
    mlast[d] = cyc;
    idx = mlookup(d, name);
    if (kind == SRC) begin
      msrc[d] = idx;
    end else begin
      medges[d]++;
      e.dut = d; e.cyc = cyc + 3; e.src = msrc[d]; e.dst = idx; e.ec = medges[d] & 16'hffff;
      expq.push_back(e);
    end
  endfunction

  function automatic void model_reset(input int d);
    int keys[$];
    mcount[d] = 0; medges[d] = 0; msrc[d] = 0; mlast[d] = -100;
    merr[d] = 1'b0; mdone[d] = 1'b0; mrel[d] = 1 << 30;
    foreach (mtab[k]) if ((k >> 16) == d) keys.push_back(k);
    foreach (keys[i]) mtab.delete(keys[i]);
    for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].dut == d) expq.delete(i);
  endfunction

  // ---------------- per-cycle compare of the edge stream ----------------
  always @(negedge clk) begin
    int j;
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      if (rstn[d] == 1'b1) begin
        j = -1;
        foreach (expq[k]) if (expq[k].dut == d && expq[k].cyc == cyc) j = k;
        if (j >= 0) begin
          chk($sformatf("edge%0d valid", d), int'(iev[d]), 1);
          chk($sformatf("edge%0d src_idx", d), int'(sidx[d]), expq[j].src);
          chk($sformatf("edge%0d dst_idx", d), int'(didx[d]), expq[j].dst);
          chk($sformatf("edge%0d edge_count", d), int'(ecnt[d]), expq[j].ec);
          expq.delete(j);
        end else if (mready(d)) begin
          chk($sformatf("edge%0d spurious valid", d), int'(iev[d]), 0);
        end
        if (iev[d]) begin
          o.cyc = cyc; o.src = int'(sidx[d]); o.dst = int'(didx[d]);
          if (d == 0) obs_a.push_back(o); else obs_b.push_back(o);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d, input int kind, input int name, input int gap);
    model_event(d, kind, name);
    case (kind)
      SRC: begin snv[d] = 1'b1; sn[d] = 15'(name); end
      EDG: begin env[d] = 1'b1; dn[d] = 15'(name); end
      default: ddv[d] = 1'b1;
    endcase
    $display("dut%0d cycle %0d: event kind=%0d name=%0d", d, cyc, kind, name);
    step();
    snv[d] = 1'b0; env[d] = 1'b0; ddv[d] = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic wait_init(input int d);
    int k;
    for (k = 1; k <= 40000; k++) begin
      step();
      if (initd[d]) break;
    end
    chk($sformatf("init%0d latency", d), k, INIT_CYCLES);
    chk($sformatf("init%0d error", d), int'(errs[d]), 0);
  endtask

  task automatic chk_model(input int d);
    chk($sformatf("model%0d node_count", d), int'(ncnt[d]), mcount[d]);
    chk($sformatf("model%0d edge_count", d), int'(ecnt[d]), medges[d] & 16'hffff);
    chk($sformatf("model%0d error", d), int'(errs[d]), int'(merr[d]));
    chk($sformatf("model%0d src_idx", d), int'(sidx[d]), msrc[d]);
  endtask

  // ---------------- instance A: line traffic, self-edge, done ----------------
  task automatic run_a();
    int want[8];
    int cnt;
    want = '{0, 1, 0, 2, 1, 2, 1, 1};
    wait_init(0);
    pulse(0, SRC, NAAA, 4);
    pulse(0, EDG, NBBB, 4);
    pulse(0, EDG, NCCC, 4);
    pulse(0, SRC, NBBB, 4);
    pulse(0, EDG, NCCC, 4);
    pulse(0, EDG, NBBB, 6);   // self-edge on the current line head
    chk_model(0);
    chk("a node_count", int'(ncnt[0]), 3);
    chk("a edge_count", int'(ecnt[0]), 4);
    chk("a error", int'(errs[0]), 0);
    chk("a edges seen", obs_a.size(), 4);
    for (int i = 0; i < obs_a.size() && i < 4; i++) begin
      chk($sformatf("a edge %0d src", i), obs_a[i].src, want[2*i]);
      chk($sformatf("a edge %0d dst", i), obs_a[i].dst, want[2*i+1]);
    end
    pulse(0, DON, 0, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (idone[0]) cnt++;
      step();
    end
    chk("a indexing_done pulses", cnt, 1);
    chk("a error after done", int'(errs[0]), 0);
    pulse(0, EDG, NCCC, 6);   // ignored once finished
    chk("a edge_count in DONE", int'(ecnt[0]), 4);
    chk("a node_count in DONE", int'(ncnt[0]), 3);
  endtask

  // ---------------- instance B: latency, drop, reset, overflow ----------------
  task automatic run_b();
    int names[5];
    int want[5];
    int t_edge;
    names = '{NDDD, NEEE, NFFF, NGGG, NHHH};
    want  = '{0, 1, 2, 3, 3};
    wait_init(1);
    pulse(1, SRC, NYOU, 3);
    t_edge = cyc;
    pulse(1, EDG, NOUT, 5);
    chk("b edges seen", obs_b.size(), 1);
    if (obs_b.size() > 0) begin
      chk("b edge latency", obs_b[0].cyc - t_edge, 3);
      chk("b you/out src", obs_b[0].src, 0);
      chk("b you/out dst", obs_b[0].dst, 1);
    end
    chk("b node_count", int'(ncnt[1]), 2);
    chk("b edge_count", int'(ecnt[1]), 1);
    chk("b error clean", int'(errs[1]), 0);
    chk_model(1);

    // edge only two cycles after a src event is dropped
    pulse(1, SRC, NAAA, 2);
    pulse(1, EDG, NBBB, 5);
    chk("b dropped edge count", obs_b.size(), 1);
    chk("b edge_count after drop", int'(ecnt[1]), 1);
    chk("b error after drop", int'(errs[1]), 1);
    chk("b node_count after drop", int'(ncnt[1]), 3);
    chk_model(1);

    // reset while a miss is in RESOLVE
    model_event(1, SRC, NCCC);
    snv[1] = 1'b1; sn[1] = 15'(NCCC);
    step();
    snv[1] = 1'b0;
    step();
    rstn[1] = 1'b0;
    #1;
    $display("dut1 cycle %0d: reset asserted in RESOLVE", cyc);
    chk("b rst init_done", int'(initd[1]), 0);
    chk("b rst idx_edge_valid", int'(iev[1]), 0);
    chk("b rst indexing_done", int'(idone[1]), 0);
    chk("b rst error", int'(errs[1]), 0);
    chk("b rst src_idx", int'(sidx[1]), 0);
    chk("b rst dst_idx", int'(didx[1]), 0);
    chk("b rst node_count", int'(ncnt[1]), 0);
    chk("b rst edge_count", int'(ecnt[1]), 0);
    model_reset(1);
    step();
    step();
    rstn[1] = 1'b1;
    mrel[1] = cyc;
    wait_init(1);

    // five distinct names into a four-entry index space
    for (int i = 0; i < 5; i++) begin
      pulse(1, SRC, names[i], 3);
      chk($sformatf("b name %0d src_idx", i), int'(sidx[1]), want[i]);
      if (i == 3) chk("b error before overflow", int'(errs[1]), 0);
    end
    chk("b overflow node_count", int'(ncnt[1]), 4);
    chk("b overflow error", int'(errs[1]), 1);
    chk_model(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 2'b00; snv = '0; env = '0; ddv = '0; sn = '0; dn = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) step();
    chk("reset init_done", int'(initd[0]), 0);
    chk("reset idx_edge_valid", int'(iev[0]), 0);
    chk("reset indexing_done", int'(idone[0]), 0);
    chk("reset error", int'(errs[0]), 0);
    chk("reset node_count", int'(ncnt[0]), 0);
    chk("reset edge_count", int'(ecnt[0]), 0);
    chk("reset src_idx", int'(sidx[0]), 0);
    chk("reset dst_idx", int'(didx[0]), 0);
    rstn = 2'b11;
    mrel[0] = cyc;
    mrel[1] = cyc;
    fork
      run_a();
      run_b();
    join
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/node_indexer.md
NODE_INDEXER -- requirements
Module: node_indexer

Interface
REQ-001 Parameter INDEX_WIDTH, default 10, SHALL set the width of the dense node index (capacity 2^INDEX_WIDTH nodes).
REQ-002 Parameter NODE_WIDTH, default 15, SHALL set the packed node-name width (3 letters x 5 bits); not overridden.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  sole clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- src_node_valid  in  1  one-cycle pulse: src_node holds a completed line-head name.
- src_node  in  NODE_WIDTH  packed line-head name; first letter in [4:0], 'a'=0.
- edge_valid  in  1  one-cycle pulse: dst_node holds a completed destination name.
- dst_node  in  NODE_WIDTH  packed destination name, same packing.
- decoding_done  in  1  one-cycle pulse: end of input.
- init_done  out  1  high once the name table is cleared; inputs accepted only when high.
- idx_edge_valid  out  1  one-cycle pulse: indexed edge on src_idx/dst_idx.
- src_idx  out  INDEX_WIDTH  dense index of current line-head node.
- dst_idx  out  INDEX_WIDTH  dense index of destination node.
- node_count  out  INDEX_WIDTH+1  number of distinct names allocated.
- edge_count  out  16  number of idx_edge_valid pulses issued, wraps mod 2^16.
- indexing_done  out  1  one-cycle pulse: all prior events processed, counts final.
- error  out  1  sticky: overflow, collision, or input during INIT.

Function
REQ-004 Name table SHALL be a 2^NODE_WIDTH-entry synchronous-read RAM addressed by packed name, each entry {valid, INDEX_WIDTH index}.
REQ-005 FSM states SHALL be INIT, IDLE, READ, RESOLVE, DONE.
REQ-006 INIT SHALL write valid=0 to one address per cycle, addresses 0..2^NODE_WIDTH-1, then go IDLE and set init_done=1 (exactly 2^NODE_WIDTH cycles after reset release).
REQ-007 In IDLE, a src_node_valid or edge_valid pulse SHALL capture the name and event kind and go READ; next cycle RESOLVE; next cycle IDLE.
REQ-008 RESOLVE hit (valid=1) SHALL use the stored index; miss SHALL use node_count as the index, write {1, node_count} to the table, and increment node_count.
REQ-009 A resolved src event SHALL update the src_idx register only; no output pulse.
REQ-010 A resolved edge event SHALL drive dst_idx, pulse idx_edge_valid, and increment edge_count in the cycle after RESOLVE (3 cycles after edge_valid); src_idx unchanged.
REQ-011 Minimum event spacing SHALL be 3 cycles; an event arriving in READ or RESOLVE SHALL be dropped and set error.
REQ-012 Simultaneous src_node_valid and edge_valid in IDLE SHALL process the edge, drop the src event, and set error.
REQ-013 A miss with node_count = 2^INDEX_WIDTH SHALL not allocate, SHALL set error, SHALL use index 2^INDEX_WIDTH-1; node_count saturates.
REQ-014 Any input pulse while init_done=0 SHALL be ignored and set error.
REQ-015 decoding_done SHALL be latched; once FSM reaches IDLE with it latched, indexing_done SHALL pulse one cycle, and FSM SHALL enter DONE, ignoring all further inputs until reset.
REQ-016 A self-edge (dst equal to current src name) SHALL yield dst_idx = src_idx without extra allocation.

Reset
REQ-017 On rst_n low, SHALL immediately set FSM=INIT, INIT address=0, init_done=0, idx_edge_valid=0, indexing_done=0, src_idx=0, dst_idx=0, node_count=0, edge_count=0, error=0, decoding_done latch=0.
REQ-018 Reset mid-operation SHALL abandon any in-flight event and restart the full INIT sweep; RAM contents are not relied upon.

Verification
REQ-019 Reset release -> init_done rises after exactly 32768 cycles; error=0.
REQ-020 src "you" (20952), edge "out" (20110) -> idx_edge_valid 3 cycles after edge_valid, src_idx=0, dst_idx=1, node_count=2, edge_count=1.
REQ-021 Lines "aaa: bbb ccc", "bbb: ccc" (events 4 cycles apart) -> edges (0,1),(0,2),(1,2); node_count=3; then decoding_done -> indexing_done pulse, error=0.
REQ-022 edge_valid 2 cycles after src_node_valid -> edge dropped, no idx_edge_valid, error=1.
REQ-023 INDEX_WIDTH=2, five distinct names -> node_count=4, fifth gets index 3, error=1.
REQ-024 rst_n low during RESOLVE of a miss -> all outputs zero at once; after new INIT, first name again gets index 0.
